// File: rtl/test_sequencer.sv
// Console test sequencer: key pulse, run/stop wait, core dump stream.
// Define DUMP_FMEM_EN to also dump fast memory for words 0..15.
module test_sequencer #(
  parameter int NKEYS       = 12,
  parameter int DELAY_CYC   = 10,
  parameter int PULSE_CYC   = 100,
  parameter int TIMEOUT_CYC = 2000,
  parameter int DUMP_WORDS  = 40,
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KW-1:0]    key_sel,
  output logic [NKEYS-1:0] key,
  input  logic             stop_in,
  output logic [17:0]      mem_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [35:0]      mem_data,
  input  logic [35:0]      fm_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [17:0]      dump_addr,
  output logic [35:0]      dump_core,
  output logic [35:0]      dump_fm,
  output logic             busy,
  output logic             timed_out
);

  typedef enum logic [2:0] {
    IDLE, DELAY, PULSE, RUN, REQ, OUT, DONE
  } state_t;

  localparam logic [23:0] DLY_LD = 24'(DELAY_CYC - 1);
  localparam logic [23:0] PLS_LD = 24'(PULSE_CYC - 1);
  localparam logic [23:0] TMO_LD = 24'(TIMEOUT_CYC - 1);
  localparam logic [18:0] NWORDS = 19'(DUMP_WORDS);

  state_t       state, state_nxt;
  logic [23:0]  cnt, cnt_nxt;
  logic [KW-1:0] sel, sel_nxt;
  logic         stop_seen, stop_nxt;
  logic [18:0]  addr, addr_nxt, addr_inc;
  logic [35:0]  core_q, core_nxt;
  logic         to_q, to_nxt;

  assign addr_inc = addr + 19'd1;

  // Next-state and datapath updates for the whole sequence.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    stop_nxt  = stop_seen;
    addr_nxt  = addr;
    core_nxt  = core_q;
    to_nxt    = to_q;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DELAY;
          sel_nxt   = key_sel;
          cnt_nxt   = DLY_LD;
          stop_nxt  = 1'b0;
          addr_nxt  = '0;
          to_nxt    = 1'b0;
        end
      end
      DELAY: begin
        stop_nxt = stop_seen | stop_in;
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = PLS_LD;
        end else begin
          cnt_nxt = cnt - 24'd1;
        end
      end
      PULSE: begin
        stop_nxt = stop_seen | stop_in;
        if (cnt == '0) begin
          state_nxt = RUN;
          cnt_nxt   = TMO_LD;
        end else begin
          cnt_nxt = cnt - 24'd1;
        end
      end
      RUN: begin
        if (stop_seen || stop_in) begin
          state_nxt = REQ;
          to_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = REQ;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt - 24'd1;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nxt = OUT;
          core_nxt  = mem_data;
        end
      end
      OUT: begin
        if (dump_ready) begin
          addr_nxt  = addr_inc;
          state_nxt = (addr_inc < NWORDS) ? REQ : DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      stop_seen <= 1'b0;
      addr      <= '0;
      core_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      stop_seen <= stop_nxt;
      addr      <= addr_nxt;
      core_q    <= core_nxt;
      to_q      <= to_nxt;
    end
  end

`ifdef DUMP_FMEM_EN
  logic [35:0] fm_q;

  // Fast memory shadows only the first 16 core addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fm_q <= '0;
    end else if (state == REQ && mem_ack) begin
      fm_q <= (addr < 19'd16) ? fm_data : '0;
    end
  end

  assign dump_fm = fm_q;
`else
  logic unused_fm;
  assign unused_fm = ^fm_data;
  assign dump_fm   = '0;
`endif

  // Moore outputs decoded from state.
  always_comb begin
    key = '0;
    if (state == PULSE && 32'(sel) < NKEYS) begin
      key = NKEYS'(1) << sel;
    end
  end

  assign mem_req    = (state == REQ);
  assign mem_addr   = addr[17:0];
  assign dump_valid = (state == OUT);
  assign dump_addr  = addr[17:0];
  assign dump_core  = core_q;
  assign busy       = (state != IDLE) && (state != DONE);
  assign timed_out  = to_q;

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter NKEYS, default 12: number of console key outputs.
REQ-002 SHALL have parameter DELAY_CYC, default 10: clocks from start to key assertion, range 1..65535.
REQ-003 SHALL have parameter PULSE_CYC, default 100: clocks the selected key is held, range 1..65535.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2000: run clocks before a forced stop, range 1..2^24-1.
REQ-005 SHALL have parameter DUMP_WORDS, default 40 (octal 50): number of core words dumped, range 1..2^18.
REQ-006 SHALL have ports:
  clk  in  1  system clock; all state on rising edge.
  reset  in  1  asynchronous, active-low.
  start  in  1  one-clock pulse that begins a sequence.
  key_sel  in  clog2(NKEYS)  key index, sampled on start.
  key  out  NKEYS  one-hot key drive.
  stop_in  in  1  machine stop indication (processor halt state).
  mem_addr  out  18  core read address.
  mem_req  out  1  core read request.
  mem_ack  in  1  core read acknowledge; data valid with ack.
  mem_data  in  36  core read data.
  fm_data  in  36  fast-memory word at mem_addr[3:0], combinational, valid every cycle.
  dump_valid  out  1  dump word available.
  dump_ready  in  1  consumer accepts word.
  dump_addr  out  18  address of the dumped word.
  dump_core  out  36  core word.
  dump_fm  out  36  fast-memory word, or 0.
  busy  out  1  sequence in progress.
  timed_out  out  1  run ended by timeout, not by stop_in.

Function
REQ-007 SHALL implement the states IDLE, DELAY, PULSE, RUN, REQ, OUT and DONE.
REQ-008 IDLE: on start, key_sel is latched, the counter is loaded, the state goes to DELAY, and busy=1 from the next clock.
REQ-009 DELAY SHALL last exactly DELAY_CYC clocks, then go to PULSE.
REQ-010 PULSE: key[sel]=1 for exactly PULSE_CYC clocks, and all other key bits are 0.
REQ-011 key_sel >= NKEYS SHALL be treated as no key: key stays 0, and the timing is unchanged.
REQ-012 RUN SHALL exit on the first clock where stop_in=1, or after TIMEOUT_CYC clocks.
REQ-013 A timeout exit SHALL set timed_out=1.
REQ-014 stop_in asserted during DELAY or PULSE SHALL be remembered, and RUN SHALL exit on its first clock.
REQ-015 If stop_in and the timeout occur on the same clock, the exit SHALL count as a stop exit: timed_out=0.
REQ-016 REQ: mem_req=1 and mem_addr=current address, held stable until mem_ack.
REQ-017 On mem_ack, mem_data SHALL be captured into dump_core, mem_req SHALL drop the next clock, and the state goes to OUT.
REQ-018 mem_ack outside REQ SHALL be ignored.
REQ-019 OUT: dump_valid=1, with dump_addr, dump_core and dump_fm stable until dump_ready.
REQ-020 An OUT transfer SHALL complete on a clock with dump_valid=1 and dump_ready=1.
REQ-021 After a transfer, the address SHALL increment; the state returns to REQ if address < DUMP_WORDS, else goes to DONE.
REQ-022 The dump SHALL start at address 0, with no wrap; the last address is DUMP_WORDS-1.
REQ-023 DONE: busy=0 and timed_out is held, until the next start returns to DELAY.
REQ-024 start SHALL be ignored in every state other than IDLE and DONE.
REQ-025 The address counter SHALL be 19 bits wide so that DUMP_WORDS=2^18 terminates.

Reset
REQ-026 reset=0 SHALL force, asynchronously: state IDLE, key=0, mem_req=0, mem_addr=0, dump_valid=0, dump_addr=0, dump_core=0, dump_fm=0, busy=0, timed_out=0, all counters 0.
REQ-027 Reset during any state, including mid-handshake, SHALL abort the sequence, and a pending mem_ack SHALL be dropped.
REQ-028 Release SHALL be synchronous to clk; the first start is accepted on the clock after release.

Configuration
REQ-029 With macro DUMP_FMEM_EN defined, the block SHALL capture fm_data into dump_fm on mem_ack for addresses 0..15, and dump_fm=0 for addresses >= 16.
REQ-030 Without DUMP_FMEM_EN, dump_fm SHALL be constant 0 and fm_data unused, with all other behaviour identical.

Verification
REQ-031 Key timing scenario: DELAY_CYC=10, PULSE_CYC=100, key_sel=1, start at cycle 0 -> key=2 in cycles 11..110, 0 otherwise.
REQ-032 Stop exit scenario: stop_in rises 50 cycles into RUN -> timed_out=0, and mem_req rises within 2 clocks.
REQ-033 Timeout scenario: TIMEOUT_CYC=2000, stop_in never asserted -> timed_out=1, then 40 words dumped in order, addresses 0..47 octal.
REQ-034 Handshake scenario: memory model acks after 0..5 random wait clocks, dump_ready randomly stalled, core[020]=200064000104 -> word at address 020 emitted exactly once with that value, and no word lost or duplicated.
REQ-035 Configuration scenario: DUMP_FMEM_EN defined, fm[017]=777000001000 -> dump_fm at address 017 = 777000001000, and at 020 = 0; macro undefined -> always 0.
REQ-036 Reset scenario: reset pulled low while in REQ with mem_req=1 -> all outputs 0 immediately, and a later start restarts from DELAY with address 0.
